// File: rtl/mem_dados_arbiter_if.sv
// mem_dados_arbiter_if: CPU/debug requester ports and data-memory bus for mem_dados_arbiter
interface mem_dados_arbiter_if;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_endereco, mem_dado, mem_readdata;
  logic        mem_memwrite, mem_memread;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_readdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, mem_endereco, mem_dado, mem_memwrite, mem_memread
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_readdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, mem_endereco, mem_dado, mem_memwrite, mem_memread
  );
endinterface

// File: rtl/mem_dados_arbiter.sv
// mem_dados_arbiter: round-robin CPU/debug arbiter for the data memory; MEM_ADDR_CHECK_EN enables out-of-range address errors
module mem_dados_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_dados_arbiter_if.slave  bus,
  output logic                busy,
  output logic                err
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_t;
  state_t            state_q, state_d;
  logic              grant_q, grant_d, last_grant_q, last_grant_d;
  logic              we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              pick_dbg, bad_addr;
  logic [31:0]       req_addr;
  always_comb begin
    pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_grant_q);
    req_addr = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
`ifdef MEM_ADDR_CHECK_EN
    bad_addr = req_addr >= 32'(DEPTH);
`else
    bad_addr = 1'b0;
`endif
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      IDLE: if (bus.cpu_req | bus.dbg_req) begin
        grant_d = pick_dbg;
        we_d    = pick_dbg ? bus.dbg_we : bus.cpu_we;
        addr_d  = req_addr[ADDR_W-1:0];
        wdata_d = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        err_d   = bad_addr;
        state_d = bad_addr ? DONE : we_d ? WR_ISSUE : RD_ISSUE;
        cpu_rdata_d = (bad_addr & ~pick_dbg) ? '0 : cpu_rdata_q;
        dbg_rdata_d = (bad_addr & pick_dbg) ? '0 : dbg_rdata_q;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        cpu_rdata_d = grant_q ? cpu_rdata_q : bus.mem_readdata;
        dbg_rdata_d = grant_q ? bus.mem_readdata : dbg_rdata_q;
        state_d     = DONE;
      end
      WR_ISSUE: state_d = DONE;
      DONE: begin
        last_grant_d = grant_q;
        err_d        = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end
  always_comb begin
    bus.mem_memread  = state_q == RD_ISSUE;
    bus.mem_memwrite = state_q == WR_ISSUE;
    bus.mem_endereco = (bus.mem_memread | bus.mem_memwrite) ? {{(32-ADDR_W){1'b0}}, addr_q} : '0;
    bus.mem_dado     = bus.mem_memwrite ? wdata_q : '0;
    bus.cpu_ack      = (state_q == DONE) & ~grant_q;
    bus.dbg_ack      = (state_q == DONE) & grant_q;
    bus.cpu_rdata    = cpu_rdata_q;
    bus.dbg_rdata    = dbg_rdata_q;
    busy             = state_q != IDLE;
    err              = (state_q == DONE) & err_q;
  end
endmodule

// File: doc/mem_dados_arbiter.md
Name: mem_dados_arbiter

Overview:
- Controller and arbiter in front of the 32-word data memory of the multicycle MIPS datapath.
- Shares the memory between two requesters: the CPU load/store port and a debug/loader port.
- Sequences each access as a strobed memread/memwrite transaction with a req/ack handshake per requester.
- Holds every memory strobe low except in the single issue cycle, so the memory never sees overlapping accesses.

Parameters:
- DEPTH, 32, number of 32-bit words in the data memory.
- ADDR_W, 5, index bits used to address memory; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load; stable while cpu_req is high.
- cpu_addr  in  32  CPU word address.
- cpu_wdata  in  32  CPU store data.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  32  CPU load data; valid while cpu_ack is high.
- dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0]  in  same meaning as the cpu_* inputs, debug port.
- dbg_ack  out  1  one-cycle completion pulse to debug port.
- dbg_rdata  out  32  debug load data; valid while dbg_ack is high.
- mem_endereco  out  32  memory word address, zero-extended from ADDR_W bits.
- mem_dado  out  32  memory write data.
- mem_memwrite  out  1  memory write strobe.
- mem_memread  out  1  memory read strobe.
- mem_readdata  in  32  memory read data; valid one cycle after mem_memread.
- busy  out  1  high in any state other than IDLE.
- err  out  1  address-error flag; see Optional Feature.

Behaviour:
- Reset values: every output is 0, state = IDLE, last_grant = DBG (so the CPU wins the first tie).
- Asynchronous reset mid-transaction aborts it. No ack is issued, strobes drop at once, and a write issued in the same cycle is not guaranteed.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
- IDLE arbitration, when any req is high:
  - Only one requester active: it is granted.
  - Both active: the requester that is not last_grant is granted (round-robin).
  - The grant, we, address and wdata are latched into internal registers.
  - Next state is RD_ISSUE or WR_ISSUE according to the latched we.
- RD_ISSUE: mem_memread = 1 and mem_endereco = latched address for exactly one cycle; next state RD_WAIT.
- RD_WAIT: mem_readdata is captured into the granted port's rdata register; next state DONE.
- WR_ISSUE: mem_memwrite = 1 and mem_dado = latched wdata for exactly one cycle; next state DONE.
- DONE:
  - The granted port's ack = 1 for one cycle; last_grant is updated.
  - Next state is IDLE; new arbitration happens in the following cycle, so there is no back-to-back grant in DONE.
- Latency, with req first sampled at edge N in IDLE:
  - Write: strobe in cycle N+1, ack in cycle N+2.
  - Read: strobe in cycle N+1, capture at N+2, ack in cycle N+3.
- The rdata register of the non-granted port holds its old value.
- Request handling:
  - A req that deasserts before its ack does not cancel the transaction; it completes and the ack still pulses.
  - A requester must drop req in the cycle after its ack, or it is treated as a new request.
- Both requesters continuously active: grants alternate CPU, DBG, CPU, ... with no starvation.
- Address mapping: only addr[ADDR_W-1:0] drives mem_endereco; upper bits are zero.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a granted address >= DEPTH skips the memory entirely; no strobe is asserted.
  - The FSM goes straight to DONE; ack pulses in cycle N+1 with rdata = 0 and err = 1 for that same cycle.
  - err is 0 at all other times.
- Undefined:
  - err is tied to 0.
  - Out-of-range addresses silently wrap to addr[ADDR_W-1:0].

Test Plan:
- Reset then CPU store addr 3, data 1235 -> mem_memwrite high for one cycle with endereco=3, dado=1235; cpu_ack at N+2; dbg_ack stays 0.
- Debug load addr 3 with mem_readdata=1235 -> mem_memread one cycle at N+1; dbg_ack at N+3 with dbg_rdata=1235; cpu_rdata unchanged.
- cpu_req and dbg_req rise in the same cycle after reset -> CPU granted first, DBG next; with both held, grant order is C, D, C, D over four transactions.
- rst_n pulsed low during RD_WAIT -> outputs 0 immediately, no ack; a following CPU read completes normally with 3-cycle latency.
- cpu_req dropped the cycle after grant -> transaction still completes, cpu_ack pulses once, FSM returns to IDLE.
- CPU store to addr 40 -> with MEM_ADDR_CHECK_EN: no strobe, ack at N+1, err=1. Without the macro: write lands at endereco=8, err=0.
